// File: rtl/sram_ctrl_pkg.sv
// Shared state encoding and width constants for the Wishbone-to-SRAM controller.
package sram_ctrl_pkg;

   localparam int HW_W   = 16;
   localparam int WORD_W = 32;

   typedef logic [2:0] state_t;

   localparam state_t S_IDLE     = 3'd0;
   localparam state_t S_RD_A     = 3'd1;
   localparam state_t S_RD_B     = 3'd2;
   localparam state_t S_WR_SETUP = 3'd3;
   localparam state_t S_WR_PULSE = 3'd4;
   localparam state_t S_WR_HOLD  = 3'd5;
   localparam state_t S_ACK      = 3'd6;

   // Byte-select pair of a halfword: H0 uses sel[3:2], H1 uses sel[1:0].
   function automatic logic [1:0] half_sel(input logic [3:0] sel, input logic half);
      return half ? sel[1:0] : sel[3:2];
   endfunction

endpackage

// File: rtl/sram_io.sv
// SRAM pin registers, tristate data driver and read-capture register.
module sram_io
   import sram_ctrl_pkg::*;
#(
   parameter int ADDR_W = 18
) (
   input  logic              clock_50,
   input  logic              reset,
   input  logic [ADDR_W-1:0] addr_d,
   input  logic              ce_n_d,
   input  logic              oe_n_d,
   input  logic              we_n_d,
   input  logic              ub_n_d,
   input  logic              lb_n_d,
   input  logic [HW_W-1:0]   dq_d,
   input  logic              dq_oe_d,
   input  logic              cap_hi,
   input  logic              cap_lo,
   output logic [ADDR_W-1:0] sram_addr,
   output logic              sram_ce_n,
   output logic              sram_oe_n,
   output logic              sram_we_n,
   output logic              sram_ub_n,
   output logic              sram_lb_n,
   inout  wire  [HW_W-1:0]   sram_dq,
   output logic [WORD_W-1:0] rd_dat
);

   logic [HW_W-1:0] dq_q;
   logic            dq_oe;

   assign sram_dq = dq_oe ? dq_q : {HW_W{1'bz}};

   // Pin registers: every SRAM output leaves the block straight from a flop.
   always_ff @(posedge clock_50) begin
      if (reset) begin
         sram_addr <= '0;
         sram_ce_n <= 1'b1;
         sram_oe_n <= 1'b1;
         sram_we_n <= 1'b1;
         sram_ub_n <= 1'b1;
         sram_lb_n <= 1'b1;
         dq_q      <= '0;
         dq_oe     <= 1'b0;
      end else begin
         sram_addr <= addr_d;
         sram_ce_n <= ce_n_d;
         sram_oe_n <= oe_n_d;
         sram_we_n <= we_n_d;
         sram_ub_n <= ub_n_d;
         sram_lb_n <= lb_n_d;
         dq_q      <= dq_d;
         dq_oe     <= dq_oe_d;
      end
   end

   // Read capture: H0 lands in the upper half of the word, H1 in the lower.
   always_ff @(posedge clock_50) begin
      if (reset) begin
         rd_dat <= '0;
      end else if (cap_hi) begin
         rd_dat[WORD_W-1:HW_W] <= sram_dq;
      end else if (cap_lo) begin
         rd_dat[HW_W-1:0] <= sram_dq;
      end else begin
         rd_dat <= rd_dat;
      end
   end

endmodule

// File: rtl/sram_wb_ctrl.sv
// Wishbone classic slave mapping each 32-bit word onto two big-endian 16-bit SRAM halfwords.
module sram_wb_ctrl
   import sram_ctrl_pkg::*;
#(
   parameter int ADDR_W = 18,
   parameter int WB_AW  = 17
) (
   input  logic              clock_50,
   input  logic              reset,
   input  logic              wb_cyc_i,
   input  logic              wb_stb_i,
   input  logic              wb_we_i,
   input  logic [31:0]       wb_adr_i,
   input  logic [3:0]        wb_sel_i,
   input  logic [31:0]       wb_dat_i,
   output logic [31:0]       wb_dat_o,
   output logic              wb_ack_o,
   output logic [ADDR_W-1:0] sram_addr,
   inout  wire  [15:0]       sram_dq,
   output logic              sram_ce_n,
   output logic              sram_oe_n,
   output logic              sram_we_n,
   output logic              sram_ub_n,
   output logic              sram_lb_n
);

   state_t            state, ns;
   logic              half, nh, aborted, ack, we_q;
   logic [WB_AW-1:0]  adr_q, adr_n;
   logic [3:0]        sel_q, sel_n;
   logic [31:0]       dat_q, dat_n;
   logic              req, take, cont;
   logic [1:0]        hs;
   logic              ce_n_d, oe_n_d, we_n_d, ub_n_d, lb_n_d, dq_oe_d;
   logic [HW_W-1:0]   dq_d;

   assign req   = wb_cyc_i & wb_stb_i & ~wb_ack_o;
   assign take  = (state == S_IDLE) & req;
   assign cont  = wb_cyc_i & ~aborted;
   assign adr_n = take ? wb_adr_i[WB_AW+1:2] : adr_q;
   assign sel_n = take ? wb_sel_i : sel_q;
   assign dat_n = take ? wb_dat_i : dat_q;
   assign wb_ack_o = ack;

   // Next-state logic; a dropped cycle finishes the current halfword then idles.
   always_comb begin
      ns = state;
      nh = half;
      case (state)
         S_IDLE: begin
            if (!req) begin
               ns = S_IDLE;
            end else if (!wb_we_i) begin
               ns = S_RD_A;
               nh = 1'b0;
            end else if (|wb_sel_i[3:2]) begin
               ns = S_WR_SETUP;
               nh = 1'b0;
            end else if (|wb_sel_i[1:0]) begin
               ns = S_WR_SETUP;
               nh = 1'b1;
            end else begin
               ns = S_ACK;
            end
         end
         S_RD_A:     ns = S_RD_B;
         S_RD_B: begin
            if (!cont) begin
               ns = S_IDLE;
            end else if (!half) begin
               ns = S_RD_A;
               nh = 1'b1;
            end else begin
               ns = S_ACK;
            end
         end
         S_WR_SETUP: ns = S_WR_PULSE;
         S_WR_PULSE: ns = S_WR_HOLD;
         S_WR_HOLD: begin
            if (!cont) begin
               ns = S_IDLE;
            end else if (!half && (|sel_q[1:0])) begin
               ns = S_WR_SETUP;
               nh = 1'b1;
            end else begin
               ns = S_ACK;
            end
         end
         S_ACK:      ns = S_IDLE;
         default:    ns = S_IDLE;
      endcase
   end

   // Pin values for the coming state, registered in sram_io.
   always_comb begin
      hs      = half_sel(sel_n, nh);
      ce_n_d  = 1'b1;
      oe_n_d  = 1'b1;
      we_n_d  = 1'b1;
      ub_n_d  = 1'b1;
      lb_n_d  = 1'b1;
      dq_oe_d = 1'b0;
      dq_d    = nh ? dat_n[15:0] : dat_n[31:16];
      case (ns)
         S_RD_A, S_RD_B: begin
            ce_n_d = 1'b0;
            oe_n_d = 1'b0;
            ub_n_d = 1'b0;
            lb_n_d = 1'b0;
         end
         S_WR_SETUP, S_WR_PULSE, S_WR_HOLD: begin
            ce_n_d  = 1'b0;
            we_n_d  = (ns == S_WR_PULSE) ? 1'b0 : 1'b1;
            ub_n_d  = ~hs[1];
            lb_n_d  = ~hs[0];
            dq_oe_d = 1'b1;
         end
         default: begin
            ce_n_d = 1'b1;
         end
      endcase
   end

   // FSM and request latches.
   always_ff @(posedge clock_50) begin
      if (reset) begin
         state   <= S_IDLE;
         half    <= 1'b0;
         aborted <= 1'b0;
         ack     <= 1'b0;
         adr_q   <= '0;
         sel_q   <= 4'b0000;
         dat_q   <= 32'h0000_0000;
         we_q    <= 1'b0;
      end else begin
         state   <= ns;
         half    <= nh;
         ack     <= (ns == S_ACK);
         aborted <= (ns == S_IDLE) ? 1'b0 : (aborted | ~wb_cyc_i);
         adr_q   <= adr_n;
         sel_q   <= sel_n;
         dat_q   <= dat_n;
         we_q    <= take ? wb_we_i : we_q;
      end
   end

   sram_io #(.ADDR_W(ADDR_W)) u_io (
      .clock_50  (clock_50),
      .reset     (reset),
      .addr_d    ({adr_n, nh}),
      .ce_n_d    (ce_n_d),
      .oe_n_d    (oe_n_d),
      .we_n_d    (we_n_d),
      .ub_n_d    (ub_n_d),
      .lb_n_d    (lb_n_d),
      .dq_d      (dq_d),
      .dq_oe_d   (dq_oe_d),
      .cap_hi    ((state == S_RD_B) & ~half),
      .cap_lo    ((state == S_RD_B) & half),
      .sram_addr (sram_addr),
      .sram_ce_n (sram_ce_n),
      .sram_oe_n (sram_oe_n),
      .sram_we_n (sram_we_n),
      .sram_ub_n (sram_ub_n),
      .sram_lb_n (sram_lb_n),
      .sram_dq   (sram_dq),
      .rd_dat    (wb_dat_o)
   );

endmodule

// File: tb/tb_sram_wb_ctrl.sv
// Scoreboard bench for sram_wb_ctrl with a behavioural asynchronous SRAM model.
module tb_sram_wb_ctrl;

   logic        clock_50 = 1'b0;
   logic        reset;
   logic        wb_cyc_i, wb_stb_i, wb_we_i;
   logic [31:0] wb_adr_i, wb_dat_i;
   logic [3:0]  wb_sel_i;
   logic [31:0] wb_dat_o;
   logic        wb_ack_o;
   logic [17:0] sram_addr;
   wire  [15:0] sram_dq;
   logic        sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

   sram_wb_ctrl dut (
      .clock_50 (clock_50), .reset (reset),
      .wb_cyc_i (wb_cyc_i), .wb_stb_i (wb_stb_i), .wb_we_i (wb_we_i),
      .wb_adr_i (wb_adr_i), .wb_sel_i (wb_sel_i), .wb_dat_i (wb_dat_i),
      .wb_dat_o (wb_dat_o), .wb_ack_o (wb_ack_o),
      .sram_addr (sram_addr), .sram_dq (sram_dq),
      .sram_ce_n (sram_ce_n), .sram_oe_n (sram_oe_n), .sram_we_n (sram_we_n),
      .sram_ub_n (sram_ub_n), .sram_lb_n (sram_lb_n)
   );

   always #10 clock_50 = ~clock_50;

   // SRAM model: drives dq on reads, commits bytes at the edge ending a we_n pulse.
   logic [15:0] mem [0:262143];
   wire mem_drv = !sram_ce_n && !sram_oe_n && sram_we_n;
   assign sram_dq = mem_drv ? mem[sram_addr] : 16'hzzzz;

   initial begin
      for (int i = 0; i < 262144; i++) mem[i] = 16'h0000;
      mem[18'h00082] = 16'h1234;
      mem[18'h3FFFE] = 16'hCAFE;
      mem[18'h3FFFF] = 16'hF00D;
      forever begin
         @(posedge clock_50);
         if (!sram_ce_n && !sram_we_n) begin
            if (!sram_ub_n) mem[sram_addr][15:8] = sram_dq[15:8];
            if (!sram_lb_n) mem[sram_addr][7:0]  = sram_dq[7:0];
         end
      end
   end

   int cyc_cnt = 0;
   always @(posedge clock_50) cyc_cnt <= cyc_cnt + 1;

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   typedef struct {
      int          start;
      int          lat;
      logic        chk_data;
      logic [31:0] data;
   } exp_t;
   exp_t sb[$];

   // Monitor: every ack pops one expectation and checks latency and read data.
   always @(negedge clock_50) begin
      if (wb_ack_o) begin
         if (sb.size() == 0) begin
            check("unexpected_ack", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("ack_latency", cyc_cnt - e.start, e.lat);
            if (e.chk_data) check("read_data", wb_dat_o, e.data);
         end
      end
   end

   // Protocol watch on every cycle.
   int viol = 0;
   int ce_low_cnt = 0;
   int pulse_cnt = 0;
   logic last_ub, last_lb;
   always @(negedge clock_50) begin
      if (!sram_we_n && !sram_oe_n) viol <= viol + 1;
      if (mem_drv && sram_dq !== mem[sram_addr]) viol <= viol + 1;
      if (!sram_ce_n) ce_low_cnt <= ce_low_cnt + 1;
      if (!sram_we_n) begin
         pulse_cnt <= pulse_cnt + 1;
         last_ub   <= sram_ub_n;
         last_lb   <= sram_lb_n;
      end
   end

   task automatic txn(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                      input logic [31:0] dat, input int lat, input logic chk,
                      input logic [31:0] rdat, input int extra, input logic keep);
      logic got;
      exp_t e;
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
      wb_adr_i = adr;  wb_sel_i = sel;  wb_dat_i = dat;
      sb.push_back('{cyc_cnt + extra, lat, chk, rdat});
      got = 1'b0;
      for (int i = 0; i < 30 && !got; i++) begin
         @(negedge clock_50);
         if (wb_ack_o) got = 1'b1;
      end
      check("ack_seen", {31'd0, got}, 32'd1);
      if (!got) e = sb.pop_back();
      if (!keep) begin
         wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
      end
   endtask

   function automatic logic [31:0] ctrl();
      return {27'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n};
   endfunction

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int snap_ce, snap_pulse;
      logic found;
      reset = 1'b1;
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
      wb_adr_i = 32'h0; wb_sel_i = 4'h0; wb_dat_i = 32'h0;
      repeat (3) @(negedge clock_50);
      check("rst_ctrl", ctrl(), 32'h1F);
      check("rst_addr", {14'd0, sram_addr}, 32'h0);
      check("rst_ack", {31'd0, wb_ack_o}, 32'h0);
      check("rst_dat", wb_dat_o, 32'h0);
      reset = 1'b0;
      @(negedge clock_50);

      // Full-word write then read, then a back-to-back byte write.
      txn(1'b1, 32'h100, 4'hF, 32'hDEADBEEF, 7, 1'b0, 32'h0, 0, 1'b0);
      check("mem_80", {16'd0, mem[18'h80]}, 32'hDEAD);
      check("mem_81", {16'd0, mem[18'h81]}, 32'hBEEF);
      @(negedge clock_50);
      txn(1'b0, 32'h100, 4'h0, 32'h0, 5, 1'b1, 32'hDEADBEEF, 0, 1'b1);
      snap_pulse = pulse_cnt;
      txn(1'b1, 32'h100, 4'b0100, 32'h11223344, 4, 1'b0, 32'h0, 1, 1'b0);
      check("mem_80_byte", {16'd0, mem[18'h80]}, 32'hDE22);
      check("mem_81_keep", {16'd0, mem[18'h81]}, 32'hBEEF);
      check("pulse_count", pulse_cnt - snap_pulse, 32'd1);
      check("pulse_ub_n", {31'd0, last_ub}, 32'd1);
      check("pulse_lb_n", {31'd0, last_lb}, 32'd0);

      // Lower-half-only write, then read mixing preloaded and written halves.
      @(negedge clock_50);
      txn(1'b1, 32'h104, 4'b0011, 32'hAAAA5566, 4, 1'b0, 32'h0, 0, 1'b0);
      check("mem_82_keep", {16'd0, mem[18'h82]}, 32'h1234);
      @(negedge clock_50);
      txn(1'b0, 32'h104, 4'h0, 32'h0, 5, 1'b1, 32'h12345566, 0, 1'b0);

      // sel=0000 write: ack only, no SRAM activity; read data is held.
      @(negedge clock_50);
      snap_ce = ce_low_cnt;
      txn(1'b1, 32'h108, 4'h0, 32'hFFFFFFFF, 1, 1'b0, 32'h0, 0, 1'b0);
      check("sel0_ce_low_cycles", ce_low_cnt - snap_ce, 32'd0);
      check("dat_o_held", wb_dat_o, 32'h12345566);

      // Reset during the write pulse.
      @(negedge clock_50);
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
      wb_adr_i = 32'h10C; wb_sel_i = 4'hF; wb_dat_i = 32'h55AA55AA;
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         @(negedge clock_50);
         if (!sram_we_n) found = 1'b1;
      end
      check("pulse_reached", {31'd0, found}, 32'd1);
      reset = 1'b1;
      @(posedge clock_50);
      #1;
      check("rst_mid_ctrl", ctrl(), 32'h1F);
      check("rst_mid_ack", {31'd0, wb_ack_o}, 32'h0);
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
      @(negedge clock_50);
      reset = 1'b0;
      repeat (3) @(negedge clock_50);
      check("rst_mid_idle", ctrl(), 32'h1F);

      // Cycle dropped during RD_A: no ack, FSM idles.
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0;
      wb_adr_i = 32'h200; wb_sel_i = 4'hF;
      @(negedge clock_50);
      check("abort_in_rd_a", {31'd0, sram_oe_n}, 32'd0);
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
      repeat (8) @(negedge clock_50);
      check("abort_idle", ctrl(), 32'h1F);

      // Top-of-memory word: halfwords 0x3FFFE/0x3FFFF.
      txn(1'b0, 32'h0007FFFC, 4'h0, 32'h0, 5, 1'b1, 32'hCAFEF00D, 0, 1'b0);
      check("top_addr_h1", {14'd0, sram_addr}, 32'h3FFFF);

      repeat (4) @(negedge clock_50);
      check("protocol_violations", viol, 32'd0);
      check("scoreboard_empty", sb.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
